// File: rtl/uart_tx_ctrl_if.sv
// Host-write and tx_mux-drive signals of the UART transmit sequencer.
// The slave modport is the sequencer; master is the host plus tx_mux side.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [1:0]           select;
  logic                 data_bit;
  logic                 parity_bit;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, tx_done, select, data_bit, parity_bit
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, tx_done, select, data_bit, parity_bit
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start/data/[parity]/stop framing, all outputs registered.
// Frame begins the cycle after accept; tx_start is ignored while busy (no queueing).
module uart_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_ctrl_if.slave  bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_IDLE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [1:0]           select_q, select_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    select_d = select_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (bus.tx_start) begin
          state_d  = S_START;
          select_d = SEL_START;
          busy_d   = 1'b1;
          shift_d  = bus.tx_data;
          parity_d = (^bus.tx_data) ^ (PARITY_ODD != 0);
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d  = S_DATA;
          select_d = SEL_DATA;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          // Last data bit leaves the shifter untouched so data_bit holds it.
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d  = S_PARITY;
              select_d = SEL_PARITY;
            end else begin
              state_d  = S_STOP;
              select_d = SEL_IDLE;
            end
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d  = S_STOP;
          select_d = SEL_IDLE;
          baud_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          baud_d  = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        select_d = SEL_IDLE;
        busy_d   = 1'b0;
        baud_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      select_q <= SEL_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.select     = select_q;
  assign bus.data_bit   = shift_q[0];
  assign bus.parity_bit = parity_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (even parity, odd parity, no parity)
// with per-cycle line/busy/done capture compared against frame-level expectations.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int NDB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(NDB)) bus0 ();
  uart_tx_ctrl_if #(.DATA_BITS(NDB)) bus1 ();
  uart_tx_ctrl_if #(.DATA_BITS(NDB)) bus2 ();

  uart_tx_ctrl #(.DATA_BITS(NDB), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
    u_even (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uart_tx_ctrl #(.DATA_BITS(NDB), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1))
    u_odd  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  uart_tx_ctrl #(.DATA_BITS(NDB), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0))
    u_nopar(.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [1:0] sel  [3];
  logic       dbit [3];
  logic       pbit [3];
  logic       busy [3];
  logic       done [3];
  logic       line [3];

  assign sel[0] = bus0.select;   assign dbit[0] = bus0.data_bit; assign pbit[0] = bus0.parity_bit;
  assign sel[1] = bus1.select;   assign dbit[1] = bus1.data_bit; assign pbit[1] = bus1.parity_bit;
  assign sel[2] = bus2.select;   assign dbit[2] = bus2.data_bit; assign pbit[2] = bus2.parity_bit;
  assign busy[0] = bus0.tx_busy; assign done[0] = bus0.tx_done;
  assign busy[1] = bus1.tx_busy; assign done[1] = bus1.tx_done;
  assign busy[2] = bus2.tx_busy; assign done[2] = bus2.tx_done;

  // tx_mux model: select picks start(0), data, parity or idle/stop(1).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (sel[i])
        2'b00:   line[i] = 1'b0;
        2'b01:   line[i] = dbit[i];
        2'b10:   line[i] = pbit[i];
        default: line[i] = 1'b1;
      endcase
    end
  end

  logic [255:0] wave_line [3];
  logic [255:0] wave_busy [3];
  logic [255:0] wave_done [3];
  int           par_seen  [3];
  int           cyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cyc < 256) begin
        wave_line[i][cyc] = line[i];
        wave_busy[i][cyc] = busy[i];
        wave_done[i][cyc] = done[i];
      end
      if (sel[i] == 2'b10) par_seen[i] = par_seen[i] + 1;
    end
    cyc = cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      wave_line[i] = '0;
      wave_busy[i] = '0;
      wave_done[i] = '0;
      par_seen[i]  = 0;
    end
    cyc = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) @(posedge clk);
    #1;
  endtask

  // Expected waveforms covering the cycles recorded so far: idle line high.
  task automatic exp_base(output logic [255:0] l, output logic [255:0] b, output logic [255:0] d);
    l = '0; b = '0; d = '0;
    for (int c = 0; c < cyc && c < 256; c++) l[c] = 1'b1;
  endtask

  task automatic add_frame(input int st, input logic [7:0] dat, input int pen, input logic podd,
                           inout logic [255:0] l, inout logic [255:0] b, inout logic [255:0] d);
    logic [11:0] fr;
    logic        p;
    int          nb;
    nb = 2 + NDB + pen;
    p  = podd;
    fr = '1;
    fr[0] = 1'b0;
    for (int j = 0; j < NDB; j++) begin
      fr[1+j] = dat[j];
      p = p ^ dat[j];
    end
    if (pen != 0) fr[1+NDB] = p;
    for (int k = 0; k < nb * CPB; k++) begin
      l[st+k] = fr[k/CPB];
      b[st+k] = 1'b1;
    end
    d[st + nb*CPB] = 1'b1;
  endtask

  logic [255:0] el, eb, ed, el1, eb1, ed1;
  logic [10:0]  dec;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus0.tx_start = 1'b0; bus0.tx_data = '0;
    bus1.tx_start = 1'b0; bus1.tx_data = '0;
    bus2.tx_start = 1'b0; bus2.tx_data = '0;
    clear_mon();

    // Reset values while rst_n is held low
    wait_cyc(3);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("rst_sel%0d", i),  256'(sel[i]),  256'(2'b11));
      chk_eq($sformatf("rst_busy%0d", i), 256'(busy[i]), 256'(1'b0));
      chk_eq($sformatf("rst_done%0d", i), 256'(done[i]), 256'(1'b0));
      chk_eq($sformatf("rst_dbit%0d", i), 256'(dbit[i]), 256'(1'b0));
      chk_eq($sformatf("rst_pbit%0d", i), 256'(pbit[i]), 256'(1'b0));
    end
    rst_n = 1'b1;

    // Idle after release: line stays high, nothing busy
    clear_mon();
    run_to(20);
    exp_base(el, eb, ed);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("idle_line%0d", i), wave_line[i], el);
      chk_eq($sformatf("idle_busy%0d", i), wave_busy[i], eb);
    end

    // 8'hA5, even parity
    clear_mon();
    bus0.tx_data = 8'hA5; bus0.tx_start = 1'b1;
    wait_cyc(1);
    bus0.tx_start = 1'b0; bus0.tx_data = 8'h00;
    run_to(60);
    exp_base(el, eb, ed);
    add_frame(1, 8'hA5, 1, 1'b0, el, eb, ed);
    chk_eq("a5_line", wave_line[0], el);
    chk_eq("a5_busy", wave_busy[0], eb);
    chk_eq("a5_done", wave_done[0], ed);
    for (int k = 0; k < 11; k++) dec[k] = wave_line[0][2 + k*CPB];
    chk_eq("a5_bits", 256'(dec), 256'(11'h54A));
    chk_eq("a5_busy_len", 256'($countones(wave_busy[0])), 256'(44));
    exp_base(el1, eb1, ed1);
    chk_eq("a5_other_line", wave_line[1], el1);

    // Odd parity 8'h00 and no-parity 8'hFF together
    clear_mon();
    bus1.tx_data = 8'h00; bus1.tx_start = 1'b1;
    bus2.tx_data = 8'hFF; bus2.tx_start = 1'b1;
    wait_cyc(1);
    bus1.tx_start = 1'b0; bus2.tx_start = 1'b0;
    wait_cyc(40);
    chk_eq("odd_pbit", 256'(pbit[1]), 256'(1'b1));
    run_to(60);
    exp_base(el, eb, ed);
    add_frame(1, 8'h00, 1, 1'b1, el, eb, ed);
    chk_eq("odd_line", wave_line[1], el);
    chk_eq("odd_busy", wave_busy[1], eb);
    chk_eq("odd_done", wave_done[1], ed);
    exp_base(el, eb, ed);
    add_frame(1, 8'hFF, 0, 1'b0, el, eb, ed);
    chk_eq("nopar_line", wave_line[2], el);
    chk_eq("nopar_busy", wave_busy[2], eb);
    chk_eq("nopar_done", wave_done[2], ed);
    chk_eq("nopar_busy_len", 256'($countones(wave_busy[2])), 256'(40));
    chk_eq("nopar_sel10", 256'(par_seen[2]), 256'(0));

    // Mid-frame tx_start is ignored
    clear_mon();
    bus0.tx_data = 8'h81; bus0.tx_start = 1'b1;
    wait_cyc(1);
    bus0.tx_start = 1'b0;
    wait_cyc(19);
    bus0.tx_data = 8'h3C; bus0.tx_start = 1'b1;
    wait_cyc(1);
    bus0.tx_start = 1'b0;
    run_to(60);
    exp_base(el, eb, ed);
    add_frame(1, 8'h81, 1, 1'b0, el, eb, ed);
    chk_eq("mid_line", wave_line[0], el);
    chk_eq("mid_busy", wave_busy[0], eb);
    chk_eq("mid_done_cnt", 256'($countones(wave_done[0])), 256'(1));

    // Back-to-back frames with tx_start held high
    clear_mon();
    bus0.tx_data = 8'h55; bus0.tx_start = 1'b1;
    wait_cyc(10);
    bus0.tx_data = 8'hAA;
    wait_cyc(80);
    bus0.tx_start = 1'b0;
    run_to(120);
    exp_base(el, eb, ed);
    add_frame(1,  8'h55, 1, 1'b0, el, eb, ed);
    add_frame(46, 8'hAA, 1, 1'b0, el, eb, ed);
    chk_eq("b2b_line", wave_line[0], el);
    chk_eq("b2b_busy", wave_busy[0], eb);
    chk_eq("b2b_done", wave_done[0], ed);
    chk_eq("b2b_done_cnt", 256'($countones(wave_done[0])), 256'(2));

    // Reset during data bit 3 aborts the frame
    clear_mon();
    bus0.tx_data = 8'hC3; bus0.tx_start = 1'b1;
    wait_cyc(1);
    bus0.tx_start = 1'b0;
    wait_cyc(17);
    chk_eq("abort_pre_sel", 256'(sel[0]), 256'(2'b01));
    rst_n = 1'b0;
    #1;
    chk_eq("abort_sel",  256'(sel[0]),  256'(2'b11));
    chk_eq("abort_busy", 256'(busy[0]), 256'(1'b0));
    chk_eq("abort_done", 256'(done[0]), 256'(1'b0));
    wait_cyc(3);
    rst_n = 1'b1;
    run_to(80);
    chk_eq("abort_no_done", 256'($countones(wave_done[0])), 256'(0));

    clear_mon();
    bus0.tx_data = 8'h5A; bus0.tx_start = 1'b1;
    wait_cyc(1);
    bus0.tx_start = 1'b0;
    run_to(60);
    exp_base(el, eb, ed);
    add_frame(1, 8'h5A, 1, 1'b0, el, eb, ed);
    chk_eq("post_line", wave_line[0], el);
    chk_eq("post_busy", wave_busy[0], eb);
    chk_eq("post_done", wave_done[0], ed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
